// File: rtl/microbot_nav_ctrl.sv
`default_nettype none
// =============================================================================
// microbot_nav_ctrl: debounced obstacle sensors driving a motion FSM with
// brake dead-time, turn dwell, reverse escape and PWM motor drive. Rev 1.0
// =============================================================================
module microbot_nav_ctrl #(
  parameter int PWM_BITS        = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DEAD_CYCLES     = 16,
  parameter int TURN_CYCLES     = 256,
  parameter int REVERSE_CYCLES  = 512
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [2:0]          sensors,
  input  logic [PWM_BITS-1:0] speed,
  output logic [1:0]          motor_a,
  output logic [1:0]          motor_b,
  output logic [2:0]          state_o,
  output logic                busy
);

  typedef enum logic [2:0] {
    S_STANDBY = 3'd0,
    S_FWD     = 3'd1,
    S_RIGHT   = 3'd2,
    S_LEFT    = 3'd3,
    S_REV     = 3'd4,
    S_DEAD    = 3'd5
  } state_t;

  localparam int DBW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CNT_MAX = (TURN_CYCLES > REVERSE_CYCLES)
                         ? ((TURN_CYCLES > DEAD_CYCLES) ? TURN_CYCLES : DEAD_CYCLES)
                         : ((REVERSE_CYCLES > DEAD_CYCLES) ? REVERSE_CYCLES : DEAD_CYCLES);
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [DBW-1:0] c_db_last   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]  c_turn_last = CW'(TURN_CYCLES - 1);
  localparam logic [CW-1:0]  c_turn_full = CW'(TURN_CYCLES);
  localparam logic [CW-1:0]  c_rev_last  = CW'(REVERSE_CYCLES - 1);
  localparam logic [CW-1:0]  c_dead_last = CW'(DEAD_CYCLES - 1);

  logic [2:0]     sync1_q, sync2_q, filt_q;
  logic [DBW-1:0] db_cnt_q [3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      filt_q  <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= sensors;
      sync2_q <= sync1_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == c_db_last) begin
          db_cnt_q[i] <= '0;
          filt_q[i]   <= sync2_q[i];
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DBW'(1);
        end
      end
    end
  end

  state_t w_req;
  always_comb begin
    w_req = S_FWD;
    case (filt_q)
      3'b001, 3'b101:         w_req = S_LEFT;
      3'b010, 3'b100, 3'b110: w_req = S_RIGHT;
      3'b111:                 w_req = S_REV;
      default:                w_req = S_FWD;
    endcase
  end

  state_t        state_q, target_q, prev_q;
  logic          tgt_req_q, busy_q;
  logic [CW-1:0] cnt_q;
  state_t        w_exit;

  // A request-driven brake may fall back to the pre-brake state if the request reverted.
  assign w_exit = (tgt_req_q && (w_req == prev_q)) ? prev_q : target_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_STANDBY;
      target_q  <= S_STANDBY;
      prev_q    <= S_STANDBY;
      tgt_req_q <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
    end else if (!ena) begin
      state_q   <= S_STANDBY;
      target_q  <= S_STANDBY;
      tgt_req_q <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        S_STANDBY: begin
          state_q <= w_req;
          cnt_q   <= '0;
          busy_q  <= (w_req != S_FWD);
        end
        S_FWD: begin
          if (w_req != S_FWD) begin
            state_q   <= S_DEAD;
            target_q  <= w_req;
            prev_q    <= S_FWD;
            tgt_req_q <= 1'b1;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
          end
        end
        S_RIGHT, S_LEFT: begin
          if ((cnt_q >= c_turn_last) && (w_req != state_q)) begin
            state_q   <= S_DEAD;
            target_q  <= w_req;
            prev_q    <= state_q;
            tgt_req_q <= 1'b1;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
          end else begin
            if (cnt_q != c_turn_full) cnt_q <= cnt_q + CW'(1);
            busy_q <= (cnt_q < c_turn_last);
          end
        end
        S_REV: begin
          if (cnt_q == c_rev_last) begin
            state_q   <= S_DEAD;
            target_q  <= S_RIGHT;
            prev_q    <= S_REV;
            tgt_req_q <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DEAD: begin
          if (cnt_q == c_dead_last) begin
            state_q <= w_exit;
            cnt_q   <= '0;
            busy_q  <= (w_exit != S_FWD);
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= S_STANDBY;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  logic [PWM_BITS-1:0] pwm_cnt_q, w_duty;
  logic [1:0]          w_dir_a, w_dir_b, motor_a_q, motor_b_q;
  logic                w_pwm_on;

  // Direction codes are one-hot per motor, so fwd and rev can never be high together.
  always_comb begin
    w_duty  = '0;
    w_dir_a = 2'b00;
    w_dir_b = 2'b00;
    case (state_q)
      S_FWD:   begin w_duty = speed;      w_dir_a = 2'b10; w_dir_b = 2'b10; end
      S_RIGHT: begin w_duty = speed >> 1; w_dir_a = 2'b10; w_dir_b = 2'b01; end
      S_LEFT:  begin w_duty = speed >> 1; w_dir_a = 2'b01; w_dir_b = 2'b10; end
      S_REV:   begin w_duty = speed;      w_dir_a = 2'b01; w_dir_b = 2'b01; end
      default: begin w_duty = '0;         w_dir_a = 2'b00; w_dir_b = 2'b00; end
    endcase
  end

  assign w_pwm_on = (pwm_cnt_q < w_duty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
      motor_a_q <= 2'b00;
      motor_b_q <= 2'b00;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
      motor_a_q <= w_dir_a & {2{w_pwm_on}};
      motor_b_q <= w_dir_b & {2{w_pwm_on}};
    end
  end

  assign motor_a = motor_a_q;
  assign motor_b = motor_b_q;
  assign state_o = state_q;
  assign busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_microbot_nav_ctrl.sv
`default_nettype none
// tb_microbot_nav_ctrl: scenario tasks; expected per-cycle state/busy queued, pins derived from
// the previous expected state and a bench-side PWM counter.
module tb_microbot_nav_ctrl;
  localparam int PWM_BITS = 4;
  localparam logic [2:0] ST_STANDBY = 3'd0, ST_FWD = 3'd1, ST_RIGHT = 3'd2,
                         ST_LEFT = 3'd3, ST_REV = 3'd4, ST_DEAD = 3'd5;

  logic       clk = 1'b0;
  logic       rst_n, ena;
  logic [2:0] sensors;
  logic [3:0] speed;
  logic [1:0] motor_a, motor_b;
  logic [2:0] state_o;
  logic       busy;

  typedef struct packed {
    logic [2:0] st;
    logic       bz;
    logic       cb;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  int         vectors = 0;
  int         errors  = 0;
  logic [2:0] cur_st;
  logic [3:0] pwm;
  logic [1:0] ema, emb;
  logic [2:0] decode_tbl [8];

  always #5 clk = ~clk;

  microbot_nav_ctrl #(
    .PWM_BITS(PWM_BITS), .DEBOUNCE_CYCLES(2), .DEAD_CYCLES(3),
    .TURN_CYCLES(8), .REVERSE_CYCLES(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sensors(sensors), .speed(speed),
    .motor_a(motor_a), .motor_b(motor_b), .state_o(state_o), .busy(busy)
  );

  always @(negedge clk) begin
    if (motor_a === 2'b11 || motor_b === 2'b11) begin
      errors++;
      $display("FAIL pin_invariant: motor_a=%b motor_b=%b, neither may be 11", motor_a, motor_b);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [3:0] duty_of(input logic [2:0] s);
    case (s)
      ST_FWD, ST_REV:  return speed;
      ST_RIGHT, ST_LEFT: return speed >> 1;
      default:         return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] dirs_of(input logic [2:0] s);
    case (s)
      ST_FWD:   return 4'b10_10;
      ST_RIGHT: return 4'b10_01;
      ST_LEFT:  return 4'b01_10;
      ST_REV:   return 4'b01_01;
      default:  return 4'b00_00;
    endcase
  endfunction

  task automatic tick();
    logic [2:0] ps;
    logic [3:0] pp;
    ps = cur_st;
    pp = pwm;
    @(posedge clk);
    #1;
    pwm = pwm + 4'd1;
    {ema, emb} = (pp < duty_of(ps)) ? dirs_of(ps) : 4'b0000;
  endtask

  task automatic push(input logic [2:0] st, input int n, input logic bz, input logic cb);
    exp_t x;
    x.st = st; x.bz = bz; x.cb = cb;
    for (int i = 0; i < n; i++) exp_q.push_back(x);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b0; sensors = 3'b000; speed = 4'd15;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (state_o !== ST_STANDBY || motor_a !== 2'b00 || motor_b !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: got st=%0d a=%b b=%b busy=%b, want st=0 a=00 b=00 busy=0",
               state_o, motor_a, motor_b, busy);
    end
    @(negedge clk);
    rst_n = 1'b1; cur_st = ST_STANDBY; pwm = 4'd0;
  endtask

  task automatic test_fwd();
    ena = 1'b1;
    push(ST_FWD, 20, 1'b0, 1'b1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      tick(); e = exp_q.pop_front(); vectors++;
      if (state_o !== e.st || motor_a !== ema || motor_b !== emb || (e.cb && busy !== e.bz)) begin
        errors++;
        $display("FAIL fwd[%0d]: got st=%0d a=%b b=%b busy=%b, want st=%0d a=%b b=%b busy=%b",
                 i, state_o, motor_a, motor_b, busy, e.st, ema, emb, e.bz);
      end
      cur_st = e.st;
    end
  endtask

  task automatic test_glitch();
    sensors = 3'b100;
    push(ST_FWD, 9, 1'b0, 1'b1);
    push(ST_FWD, 4, 1'b0, 1'b1);
    push(ST_DEAD, 3, 1'b1, 1'b1);
    push(ST_RIGHT, 8, 1'b1, 1'b1);
    push(ST_RIGHT, 10, 1'b0, 1'b1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      if (i == 1) sensors = 3'b000;
      if (i == 9) sensors = 3'b100;
      tick(); e = exp_q.pop_front(); vectors++;
      if (state_o !== e.st || motor_a !== ema || motor_b !== emb || (e.cb && busy !== e.bz)) begin
        errors++;
        $display("FAIL glitch[%0d]: got st=%0d a=%b b=%b busy=%b, want st=%0d a=%b b=%b busy=%b",
                 i, state_o, motor_a, motor_b, busy, e.st, ema, emb, e.bz);
      end
      cur_st = e.st;
    end
  endtask

  task automatic test_turn_dwell();
    sensors = 3'b000;
    push(ST_RIGHT, 4, 1'b0, 1'b1);
    push(ST_DEAD, 3, 1'b1, 1'b1);
    push(ST_FWD, 5, 1'b0, 1'b1);
    push(ST_DEAD, 3, 1'b1, 1'b1);
    push(ST_RIGHT, 8, 1'b1, 1'b1);
    push(ST_DEAD, 3, 1'b1, 1'b1);
    push(ST_FWD, 4, 1'b0, 1'b1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      if (i == 8)  sensors = 3'b100;
      if (i == 18) sensors = 3'b000;
      tick(); e = exp_q.pop_front(); vectors++;
      if (state_o !== e.st || motor_a !== ema || motor_b !== emb || (e.cb && busy !== e.bz)) begin
        errors++;
        $display("FAIL dwell[%0d]: got st=%0d a=%b b=%b busy=%b, want st=%0d a=%b b=%b busy=%b",
                 i, state_o, motor_a, motor_b, busy, e.st, ema, emb, e.bz);
      end
      cur_st = e.st;
    end
  endtask

  task automatic test_reverse();
    sensors = 3'b111;
    push(ST_FWD, 4, 1'b0, 1'b1);
    push(ST_DEAD, 3, 1'b1, 1'b1);
    push(ST_REV, 10, 1'b1, 1'b1);
    push(ST_DEAD, 3, 1'b1, 1'b1);
    push(ST_RIGHT, 8, 1'b1, 1'b1);
    push(ST_DEAD, 3, 1'b1, 1'b1);
    push(ST_REV, 4, 1'b1, 1'b1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      tick(); e = exp_q.pop_front(); vectors++;
      if (state_o !== e.st || motor_a !== ema || motor_b !== emb || (e.cb && busy !== e.bz)) begin
        errors++;
        $display("FAIL reverse[%0d]: got st=%0d a=%b b=%b busy=%b, want st=%0d a=%b b=%b busy=%b",
                 i, state_o, motor_a, motor_b, busy, e.st, ema, emb, e.bz);
      end
      cur_st = e.st;
    end
  endtask

  task automatic test_ena();
    ena = 1'b0; sensors = 3'b001;
    push(ST_STANDBY, 6, 1'b0, 1'b1);
    push(ST_LEFT, 5, 1'b1, 1'b1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      if (i == 6) ena = 1'b1;
      tick(); e = exp_q.pop_front(); vectors++;
      if (state_o !== e.st || motor_a !== ema || motor_b !== emb || (e.cb && busy !== e.bz)) begin
        errors++;
        $display("FAIL ena[%0d]: got st=%0d a=%b b=%b busy=%b, want st=%0d a=%b b=%b busy=%b",
                 i, state_o, motor_a, motor_b, busy, e.st, ema, emb, e.bz);
      end
      cur_st = e.st;
    end
  endtask

  task automatic test_reset_mid();
    // Advance until the left motor is actively driven, then reset between edges.
    for (int k = 0; k < 16 && ema !== 2'b01; k++) begin
      tick(); vectors++;
      if (state_o !== ST_LEFT || motor_a !== ema || motor_b !== emb) begin
        errors++;
        $display("FAIL hunt[%0d]: got st=%0d a=%b b=%b, want st=%0d a=%b b=%b",
                 k, state_o, motor_a, motor_b, ST_LEFT, ema, emb);
      end
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (motor_a !== 2'b00 || motor_b !== 2'b00 || state_o !== ST_STANDBY || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got st=%0d a=%b b=%b busy=%b, want st=0 a=00 b=00 busy=0",
               state_o, motor_a, motor_b, busy);
    end
    sensors = 3'b010; ena = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; cur_st = ST_STANDBY; pwm = 4'd0;
    push(ST_FWD, 1, 1'b0, 1'b1);
    push(ST_STANDBY, 1, 1'b0, 1'b1);
    for (int c = 0; c < 8; c++) begin
      push(ST_STANDBY, 6, 1'b0, 1'b1);
      push(decode_tbl[c], 1, (decode_tbl[c] != ST_FWD), 1'b1);
      push(ST_STANDBY, 1, 1'b0, 1'b1);
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      if (i == 1) ena = 1'b0;
      if (i >= 2) begin
        if ((i - 2) % 8 == 0) begin sensors = 3'((i - 2) / 8); ena = 1'b0; end
        if ((i - 2) % 8 == 6) ena = 1'b1;
        if ((i - 2) % 8 == 7) ena = 1'b0;
      end
      tick(); e = exp_q.pop_front(); vectors++;
      if (state_o !== e.st || motor_a !== ema || motor_b !== emb || (e.cb && busy !== e.bz)) begin
        errors++;
        $display("FAIL post_reset[%0d]: got st=%0d a=%b b=%b busy=%b, want st=%0d a=%b b=%b busy=%b",
                 i, state_o, motor_a, motor_b, busy, e.st, ema, emb, e.bz);
      end
      cur_st = e.st;
    end
  endtask

  initial begin
    decode_tbl = '{ST_FWD, ST_LEFT, ST_RIGHT, ST_FWD, ST_RIGHT, ST_LEFT, ST_RIGHT, ST_REV};
    ema = 2'b00; emb = 2'b00;
    test_reset();
    test_fwd();
    test_glitch();
    test_turn_dwell();
    test_reverse();
    test_ena();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
